vram_arbiter: RTL and testbench

Shares the single-port 128x128 video RAM (14-bit address {y[6:0],x[6:0]}, 3-bit RGB word) between three requesters: display scan-out, buffered pixel writes from a drawing source, and a full-screen clear engine. Display reads have absolute priority while video is active. Writes and clears use blanking cycles only. Sits between Vga_Sync/drawing logic and VRam, all on the pixel clock.

---
 rtl/vga_pkg.sv | 25 ++
 rtl/vram_arbiter_if.sv | 29 ++
 rtl/vram_wr_fifo.sv | 45 ++++
 rtl/vram_arbiter.sv | 142 ++++++++++++++
 tb/tb_vram_arbiter.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA/VRAM definitions: address and colour widths, colour constants
// and the clear-engine state encoding.
package vga_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 3;
  localparam int X_W    = 7;
  localparam int Y_W    = 7;

  localparam logic [DATA_W-1:0] BLACK = 3'b000;
  localparam logic [DATA_W-1:0] WHITE = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    CLEAR = 2'd2
  } clr_state_t;

  // VRAM address layout is row-major: {y, x}
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [X_W-1:0] x,
                                                 input logic [Y_W-1:0] y);
    return {y, x};
  endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// Requester/memory-side signal bundle of the VRAM arbiter.
import vga_pkg::*;

interface vram_arbiter_if;
  logic              video_on;
  logic [ADDR_W-1:0] disp_addr;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              clr_start;
  logic [DATA_W-1:0] clr_color;
  logic              clr_busy;
  logic              clr_done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic              video_on_q;

  modport slave (
    input  video_on, disp_addr, wr_valid, wr_addr, wr_data, clr_start, clr_color,
    output wr_ready, clr_busy, clr_done, mem_addr, mem_we, mem_wdata, video_on_q
  );

  modport master (
    output video_on, disp_addr, wr_valid, wr_addr, wr_data, clr_start, clr_color,
    input  wr_ready, clr_busy, clr_done, mem_addr, mem_we, mem_wdata, video_on_q
  );
endinterface

// File: rtl/vram_wr_fifo.sv
// Small synchronous FIFO buffering pixel writes until a blanking slot is free.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module vram_wr_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]   r_wr_ptr;
  logic [PTR_W:0]   r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_dout    = r_mem[r_rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_din;
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display reads own active video, buffered writes
// and the full-screen clear engine share the blanking slots.
module vram_arbiter
  import vga_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  vram_arbiter_if.slave  bus
);
  localparam logic [ADDR_W-1:0] CNT_MAX = {ADDR_W{1'b1}};

  clr_state_t        r_state;
  clr_state_t        w_state_nxt;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic [DATA_W-1:0] r_clr_color;
  logic              r_clr_busy;
  logic              r_clr_done;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_we;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_video_on_q;

  logic [ADDR_W-1:0] w_mem_addr;
  logic              w_mem_we;
  logic [DATA_W-1:0] w_mem_wdata;
  logic [ADDR_W-1:0] w_clr_cnt_nxt;
  logic [DATA_W-1:0] w_clr_color_nxt;
  logic              w_clr_done_nxt;
  logic              w_pop;
  logic              w_push;
  logic              w_wr_ready;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_data;

  // Ready depends only on registered state, so a same-cycle pop never frees a full FIFO
  assign w_wr_ready = !w_fifo_full && !r_clr_busy;
  assign w_push     = bus.wr_valid && w_wr_ready;

  vram_wr_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   ({bus.wr_addr, bus.wr_data}),
    .o_dout  ({w_head_addr, w_head_data}),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // A clr_start coinciding with the done pulse is deliberately dropped
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.clr_start && !r_clr_done) w_state_nxt = PEND;
               else                              w_state_nxt = IDLE;
      PEND:    if (w_fifo_empty) w_state_nxt = CLEAR;
               else              w_state_nxt = PEND;
      CLEAR:   if (!bus.video_on && (r_clr_cnt == CNT_MAX)) w_state_nxt = IDLE;
               else                                         w_state_nxt = CLEAR;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_mem_addr      = bus.disp_addr;
    w_mem_we        = 1'b0;
    w_mem_wdata     = r_mem_wdata;
    w_pop           = 1'b0;
    w_clr_cnt_nxt   = r_clr_cnt;
    w_clr_color_nxt = r_clr_color;
    w_clr_done_nxt  = 1'b0;
    if (!bus.video_on && (r_state == CLEAR)) begin
      w_mem_addr     = r_clr_cnt;
      w_mem_wdata    = r_clr_color;
      w_mem_we       = 1'b1;
      w_clr_cnt_nxt  = r_clr_cnt + ADDR_W'(1);
      w_clr_done_nxt = (r_clr_cnt == CNT_MAX);
    end else if (!bus.video_on && !w_fifo_empty) begin
      // PEND also drains here so queued writes land before the clear
      w_mem_addr  = w_head_addr;
      w_mem_wdata = w_head_data;
      w_mem_we    = 1'b1;
      w_pop       = 1'b1;
    end else begin
      w_mem_addr = bus.disp_addr;
      w_mem_we   = 1'b0;
    end
    if ((r_state == PEND) && w_fifo_empty) begin
      w_clr_cnt_nxt = '0;
    end else begin
      w_clr_cnt_nxt = w_clr_cnt_nxt;
    end
    if ((r_state == IDLE) && (w_state_nxt == PEND)) begin
      w_clr_color_nxt = bus.clr_color;
    end else begin
      w_clr_color_nxt = r_clr_color;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clr_cnt    <= '0;
      r_clr_color  <= BLACK;
      r_clr_busy   <= 1'b0;
      r_clr_done   <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_we     <= 1'b0;
      r_mem_wdata  <= '0;
      r_video_on_q <= 1'b0;
    end else begin
      r_clr_cnt    <= w_clr_cnt_nxt;
      r_clr_color  <= w_clr_color_nxt;
      r_clr_busy   <= (w_state_nxt != IDLE);
      r_clr_done   <= w_clr_done_nxt;
      r_mem_addr   <= w_mem_addr;
      r_mem_we     <= w_mem_we;
      r_mem_wdata  <= w_mem_wdata;
      r_video_on_q <= bus.video_on;
    end
  end

  assign bus.wr_ready   = w_wr_ready;
  assign bus.clr_busy   = r_clr_busy;
  assign bus.clr_done   = r_clr_done;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.video_on_q = r_video_on_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed vector table, clear sequences, random
// traffic, all compared against a queue-based slot model.
module tb_vram_arbiter;
  import vga_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vram_arbiter_if bus();

  vram_arbiter #(.FIFO_DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  // model state
  logic [16:0] m_q[$];
  int          m_mode;   // 0 idle, 1 waiting for drain, 2 clearing
  int          m_cnt;
  logic [2:0]  m_color;
  bit          m_busy, m_done;
  logic [13:0] e_addr;
  logic        e_we, e_voq;
  logic [2:0]  e_wd;
  int          n_we, n_done;

  typedef struct {
    logic        vid;
    logic [13:0] disp;
    logic        wv;
    logic [13:0] wa;
    logic [2:0]  wd;
    logic        ready;
    logic [13:0] ea;
    logic        ewe;
    logic [2:0]  ewd;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_mode = 0; m_cnt = 0; m_color = 3'd0; m_busy = 1'b0; m_done = 1'b0;
    e_addr = 14'd0; e_we = 1'b0; e_wd = 3'd0; e_voq = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.video_on = 1'b0; bus.disp_addr = 14'd0; bus.wr_valid = 1'b0;
    bus.wr_addr = 14'd0; bus.wr_data = 3'd0; bus.clr_start = 1'b0; bus.clr_color = 3'd0;
  endtask

  // One pixel-clock cycle: inputs already driven, model advanced, outputs compared.
  task automatic step();
    bit exp_ready, fin, q_empty0;
    int nmode;
    #1;
    exp_ready = (m_q.size() < 4) && !m_busy;
    chk("wr_ready", 32'(bus.wr_ready), 32'(exp_ready));
    q_empty0 = (m_q.size() == 0);
    nmode = m_mode; fin = 1'b0;
    if (bus.video_on) begin
      e_addr = bus.disp_addr; e_we = 1'b0;
    end else if (m_mode == 2) begin
      e_addr = 14'(m_cnt); e_wd = m_color; e_we = 1'b1;
      if (m_cnt == 16383) begin fin = 1'b1; nmode = 0; m_cnt = 0; end
      else m_cnt++;
    end else if (!q_empty0) begin
      {e_addr, e_wd} = m_q.pop_front(); e_we = 1'b1;
    end else begin
      e_addr = bus.disp_addr; e_we = 1'b0;
    end
    if (m_mode == 0 && bus.clr_start && !m_done) begin
      nmode = 1; m_color = bus.clr_color;
    end
    if (m_mode == 1 && q_empty0) begin
      nmode = 2; m_cnt = 0;
    end
    if (bus.wr_valid && exp_ready) m_q.push_back({bus.wr_addr, bus.wr_data});
    e_voq = bus.video_on; m_mode = nmode; m_busy = (nmode != 0); m_done = fin;
    @(posedge clk); #1;
    chk("mem_addr",   32'(bus.mem_addr),   32'(e_addr));
    chk("mem_we",     32'(bus.mem_we),     32'(e_we));
    chk("mem_wdata",  32'(bus.mem_wdata),  32'(e_wd));
    chk("video_on_q", 32'(bus.video_on_q), 32'(e_voq));
    chk("clr_busy",   32'(bus.clr_busy),   32'(m_busy));
    chk("clr_done",   32'(bus.clr_done),   32'(m_done));
    chk("we_in_video", 32'(bus.mem_we & bus.video_on_q), 32'(0));
    if (bus.mem_we === 1'b1) n_we++;
    if (bus.clr_done === 1'b1) n_done++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    @(posedge clk); @(posedge clk); #1;
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'(0));
    chk("rst_mem_we",   32'(bus.mem_we),   32'(0));
    chk("rst_busy",     32'(bus.clr_busy), 32'(0));
    chk("rst_ready",    32'(bus.wr_ready), 32'(1));
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int we0, d0;
    bit seen;
    idle_inputs();
    n_we = 0; n_done = 0;
    model_reset();
    do_reset();

    // display priority, FIFO fill to full, in-order drain
    tbl[0]  = '{1'b1, 14'h0105, 1'b1, 14'h0203, 3'b101, 1'b1, 14'h0105, 1'b0, 3'b000};
    tbl[1]  = '{1'b0, 14'h0000, 1'b0, 14'h0000, 3'b000, 1'b1, 14'h0203, 1'b1, 3'b101};
    tbl[2]  = '{1'b1, 14'h0010, 1'b1, 14'h0001, 3'b001, 1'b1, 14'h0010, 1'b0, 3'b101};
    tbl[3]  = '{1'b1, 14'h0011, 1'b1, 14'h0002, 3'b010, 1'b1, 14'h0011, 1'b0, 3'b101};
    tbl[4]  = '{1'b1, 14'h0012, 1'b1, 14'h0003, 3'b011, 1'b1, 14'h0012, 1'b0, 3'b101};
    tbl[5]  = '{1'b1, 14'h0013, 1'b1, 14'h0004, 3'b100, 1'b1, 14'h0013, 1'b0, 3'b101};
    tbl[6]  = '{1'b1, 14'h0014, 1'b1, 14'h0005, 3'b110, 1'b0, 14'h0014, 1'b0, 3'b101};
    tbl[7]  = '{1'b0, 14'h3FFF, 1'b0, 14'h0000, 3'b000, 1'b0, 14'h0001, 1'b1, 3'b001};
    tbl[8]  = '{1'b0, 14'h3FFF, 1'b0, 14'h0000, 3'b000, 1'b1, 14'h0002, 1'b1, 3'b010};
    tbl[9]  = '{1'b0, 14'h3FFF, 1'b0, 14'h0000, 3'b000, 1'b1, 14'h0003, 1'b1, 3'b011};
    tbl[10] = '{1'b0, 14'h3FFF, 1'b0, 14'h0000, 3'b000, 1'b1, 14'h0004, 1'b1, 3'b100};
    tbl[11] = '{1'b0, 14'h0ABC, 1'b0, 14'h0000, 3'b000, 1'b1, 14'h0ABC, 1'b0, 3'b100};
    for (int i = 0; i < 12; i++) begin
      bus.video_on = tbl[i].vid; bus.disp_addr = tbl[i].disp; bus.wr_valid = tbl[i].wv;
      bus.wr_addr = tbl[i].wa; bus.wr_data = tbl[i].wd;
      #1;
      chk("tbl_ready", 32'(bus.wr_ready), 32'(tbl[i].ready));
      step();
      chk("tbl_addr",  32'(bus.mem_addr),  32'(tbl[i].ea));
      chk("tbl_we",    32'(bus.mem_we),    32'(tbl[i].ewe));
      chk("tbl_wdata", 32'(bus.mem_wdata), 32'(tbl[i].ewd));
    end

    // two queued writes, then a white clear in blanking
    we0 = n_we; d0 = n_done;
    idle_inputs(); bus.video_on = 1'b1; bus.wr_valid = 1'b1;
    bus.wr_addr = 14'h0100; bus.wr_data = 3'b001; step();
    bus.wr_addr = 14'h0101; bus.wr_data = 3'b010; step();
    idle_inputs(); bus.clr_start = 1'b1; bus.clr_color = WHITE; step();
    bus.clr_start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 17000 && !seen; c++) begin
      step();
      if (bus.clr_done === 1'b1) seen = 1'b1;
    end
    chk("clr1_done_seen", 32'(seen), 32'(1));
    bus.clr_start = 1'b1; bus.clr_color = 3'b001; step();
    bus.clr_start = 1'b0; step(); step();
    chk("clr1_busy_after", 32'(bus.clr_busy), 32'(0));
    chk("clr1_we_total",   32'(n_we - we0),   32'(16386));
    chk("clr1_done_once",  32'(n_done - d0),  32'(1));

    // clear with video toggling, ignored restarts and blocked writes
    we0 = n_we; d0 = n_done;
    idle_inputs(); bus.clr_start = 1'b1; bus.clr_color = 3'b010; step();
    seen = 1'b0;
    for (int c = 0; c < 40000 && !seen; c++) begin
      bus.video_on  = 1'($urandom_range(0, 1));
      bus.disp_addr = 14'($urandom);
      bus.clr_start = ($urandom_range(0, 99) == 0);
      bus.clr_color = 3'b111;
      bus.wr_valid  = 1'($urandom_range(0, 1));
      bus.wr_addr   = 14'($urandom);
      bus.wr_data   = 3'($urandom);
      step();
      if (bus.clr_done === 1'b1) seen = 1'b1;
    end
    idle_inputs();
    chk("clr2_done_seen", 32'(seen), 32'(1));
    chk("clr2_we_total",  32'(n_we - we0),  32'(16384));
    chk("clr2_done_once", 32'(n_done - d0), 32'(1));
    step();

    // random write traffic, no clears
    for (int c = 0; c < 2000; c++) begin
      bus.video_on  = ($urandom_range(0, 3) != 0);
      bus.disp_addr = 14'($urandom);
      bus.wr_valid  = 1'($urandom_range(0, 1));
      bus.wr_addr   = 14'($urandom);
      bus.wr_data   = 3'($urandom);
      step();
    end

    // asynchronous reset in the middle of a clear
    idle_inputs(); bus.clr_start = 1'b1; bus.clr_color = 3'b101; step();
    bus.clr_start = 1'b0;
    for (int c = 0; c < 6000 && !(m_mode == 2 && m_cnt == 'h1000); c++) step();
    chk("rst_mid_reached", 32'(m_cnt), 32'('h1000));
    d0 = n_done;
    rst = 1'b1; #1;
    chk("async_mem_addr",  32'(bus.mem_addr),   32'(0));
    chk("async_mem_we",    32'(bus.mem_we),     32'(0));
    chk("async_mem_wdata", 32'(bus.mem_wdata),  32'(0));
    chk("async_voq",       32'(bus.video_on_q), 32'(0));
    chk("async_busy",      32'(bus.clr_busy),   32'(0));
    chk("async_done",      32'(bus.clr_done),   32'(0));
    do_reset();
    for (int c = 0; c < 6; c++) step();
    chk("rst_no_done", 32'(n_done - d0), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
